hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter MUL_LAT, default 4: total stall cycles for a multiply in EX; legal range 2..255.
REQ-002 Parameter DIV_LAT, default 16: total stall cycles for a divide in EX; legal range 2..255.
REQ-003 clk  in  1  single clock; all state updates on posedge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 ID_RegRs, ID_RegRt  in  5 each  source registers of the instruction in ID.
REQ-006 ID_UsesRt  in  1  ID instruction reads rt.
REQ-007 ID_Jump  in  1  jump resolved in ID.
REQ-008 EX_MemRead  in  1  instruction in EX is a load.
REQ-009 EX_RegWrAddr  in  5  destination register of the instruction in EX.
REQ-010 EX_BranchTaken  in  1  branch resolved taken in EX.
REQ-011 EX_MDUStart, EX_MDUIsDiv  in  1 each  EX holds a mult/div; 1 = divide, 0 = multiply.
REQ-012 PC_stall, IF_ID_stall, IF_ID_flush, ID_stall, ID_flush, EX_MEM_flush  out  1 each  pipeline-register controls; ID_stall/ID_flush drive the ID/EX register, where flush has priority over stall.
REQ-013 MDU_busy  out  1  MDU stall active this cycle.
REQ-014 MDU_done  out  1  one-cycle pulse; MDU instruction advances at the next edge.
REQ-015 LoadUse_cnt, Flush_cnt  out  16 each  saturating event counters.

Function
REQ-016 The FSM SHALL have states IDLE, BUSY and DONE, plus an 8-bit down-counter cnt.
REQ-017 The load-use hazard (lu) SHALL be EX_MemRead && EX_RegWrAddr!=0 && (EX_RegWrAddr==ID_RegRs || (ID_UsesRt && EX_RegWrAddr==ID_RegRt)).
REQ-018 The MDU stall (ms) SHALL be (state==IDLE && EX_MDUStart) || state==BUSY.
REQ-019 Transition IDLE & EX_MDUStart SHALL go to BUSY, loading cnt = (EX_MDUIsDiv ? DIV_LAT : MUL_LAT) - 1.
REQ-020 In BUSY, cnt SHALL decrement each cycle; BUSY with cnt==1 SHALL go to DONE.
REQ-021 DONE SHALL go to IDLE unconditionally, and EX_MDUStart SHALL be ignored in DONE so the same instruction does not retrigger.
REQ-022 Total MDU stall SHALL be exactly LAT consecutive cycles, followed by one DONE cycle with MDU_done=1.
REQ-023 MDU_busy SHALL equal ms.
REQ-024 Outputs SHALL be combinational from state and inputs, applying only the first matching priority below; all unlisted outputs are 0.
REQ-025 Priority 1, ms: PC_stall=IF_ID_stall=ID_stall=EX_MEM_flush=1.
REQ-026 Priority 2, EX_BranchTaken: IF_ID_flush=ID_flush=1, with PC not stalled.
REQ-027 Priority 3, lu: PC_stall=IF_ID_stall=ID_flush=1 (bubble), and a simultaneous ID_Jump flush is suppressed.
REQ-028 Priority 4, ID_Jump: IF_ID_flush=1.
REQ-029 LoadUse_cnt SHALL increment on each cycle where priority 3 is applied.
REQ-030 Flush_cnt SHALL increment on each cycle where priority 2 or 4 is applied.
REQ-031 Both counters SHALL saturate at 16'hFFFF.
REQ-032 EX_BranchTaken during BUSY or DONE is not a legal stimulus; in BUSY, ms priority SHALL still apply.

Reset
REQ-033 While reset is 0, state SHALL be IDLE, cnt=0, LoadUse_cnt=0, Flush_cnt=0, and all 1-bit outputs SHALL be forced to 0 regardless of inputs.
REQ-034 Reset asserted mid-BUSY SHALL abort the operation immediately, with no MDU_done pulse.
REQ-035 After reset deassertion, the first edge SHALL evaluate from IDLE.

Verification
REQ-036 Load-use: EX_MemRead=1, EX_RegWrAddr=5, ID_RegRs=5 for one cycle -> PC_stall=IF_ID_stall=ID_flush=1 for that cycle, and LoadUse_cnt becomes 1.
REQ-037 Load-use must not fire on $zero: EX_RegWrAddr=0=ID_RegRs with EX_MemRead=1 -> all outputs 0; rt match with ID_UsesRt=0 -> also no stall.
REQ-038 Divide: EX_MDUStart=1, EX_MDUIsDiv=1 held -> MDU_busy=1 for exactly 16 cycles; then MDU_done=1 with all stalls 0 for one cycle; then IDLE with no retrigger; a multiply gives 4 cycles.
REQ-039 Priority check: EX_BranchTaken=1 with lu=1 and ID_Jump=1 -> IF_ID_flush=ID_flush=1, PC_stall=0, Flush_cnt+1, LoadUse_cnt unchanged; lu=1 with ID_Jump=1 -> stall only, IF_ID_flush=0.
REQ-040 Reset mid-operation: reset=0 at cycle 5 of a divide -> outputs 0 immediately; after release with EX_MDUStart=0 -> IDLE and MDU_done never pulses.
REQ-041 Saturation: 65540 consecutive jump cycles -> Flush_cnt holds at 16'hFFFF.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard controller: load-use bubbles, branch/jump flushes and MDU stalls.
// Also keeps saturating counters of load-use and flush events.
module hazard_ctrl #(
   parameter int unsigned MUL_LAT = 4,
   parameter int unsigned DIV_LAT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  ID_RegRs,
   input  logic [4:0]  ID_RegRt,
   input  logic        ID_UsesRt,
   input  logic        ID_Jump,
   input  logic        EX_MemRead,
   input  logic [4:0]  EX_RegWrAddr,
   input  logic        EX_BranchTaken,
   input  logic        EX_MDUStart,
   input  logic        EX_MDUIsDiv,
   output logic        PC_stall,
   output logic        IF_ID_stall,
   output logic        IF_ID_flush,
   output logic        ID_stall,
   output logic        ID_flush,
   output logic        EX_MEM_flush,
   output logic        MDU_busy,
   output logic        MDU_done,
   output logic [15:0] LoadUse_cnt,
   output logic [15:0] Flush_cnt
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [7:0] MUL_CNT = 8'(MUL_LAT - 1);
   localparam logic [7:0] DIV_CNT = 8'(DIV_LAT - 1);

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [15:0] lu_cnt_q, lu_cnt_d;
   logic [15:0] fl_cnt_q, fl_cnt_d;

   logic lu;
   logic ms;
   logic apply_lu;
   logic apply_fl;

   // Hazard detection; $zero never creates a dependency
   always_comb begin
      lu = EX_MemRead && (EX_RegWrAddr != 5'd0) &&
           ((EX_RegWrAddr == ID_RegRs) ||
            (ID_UsesRt && (EX_RegWrAddr == ID_RegRt)));
      ms = ((state_q == IDLE) && EX_MDUStart) || (state_q == BUSY);
   end

   // MDU sequencer next state; start is ignored in DONE to avoid retrigger
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (EX_MDUStart) begin
               state_d = BUSY;
               cnt_d   = EX_MDUIsDiv ? DIV_CNT : MUL_CNT;
            end
         end
         BUSY: begin
            cnt_d = cnt_q - 8'd1;
            if (cnt_q == 8'd1) state_d = DONE;
         end
         DONE: state_d = IDLE;
         default: begin
            state_d = IDLE;
            cnt_d   = 8'd0;
         end
      endcase
   end

   // Prioritised pipeline controls, all forced low while in reset
   always_comb begin
      PC_stall     = 1'b0;
      IF_ID_stall  = 1'b0;
      IF_ID_flush  = 1'b0;
      ID_stall     = 1'b0;
      ID_flush     = 1'b0;
      EX_MEM_flush = 1'b0;
      MDU_busy     = 1'b0;
      MDU_done     = 1'b0;
      apply_lu     = 1'b0;
      apply_fl     = 1'b0;
      if (reset) begin
         MDU_busy = ms;
         MDU_done = (state_q == DONE);
         if (ms) begin
            PC_stall     = 1'b1;
            IF_ID_stall  = 1'b1;
            ID_stall     = 1'b1;
            EX_MEM_flush = 1'b1;
         end else if (EX_BranchTaken) begin
            IF_ID_flush = 1'b1;
            ID_flush    = 1'b1;
            apply_fl    = 1'b1;
         end else if (lu) begin
            PC_stall    = 1'b1;
            IF_ID_stall = 1'b1;
            ID_flush    = 1'b1;
            apply_lu    = 1'b1;
         end else if (ID_Jump) begin
            IF_ID_flush = 1'b1;
            apply_fl    = 1'b1;
         end
      end
   end

   // Saturating event counters
   always_comb begin
      lu_cnt_d = lu_cnt_q;
      fl_cnt_d = fl_cnt_q;
      if (apply_lu && (lu_cnt_q != 16'hFFFF)) lu_cnt_d = lu_cnt_q + 16'd1;
      if (apply_fl && (fl_cnt_q != 16'hFFFF)) fl_cnt_d = fl_cnt_q + 16'd1;
   end

   // State and counter registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         cnt_q    <= 8'd0;
         lu_cnt_q <= 16'd0;
         fl_cnt_q <= 16'd0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         lu_cnt_q <= lu_cnt_d;
         fl_cnt_q <= fl_cnt_d;
      end
   end

   assign LoadUse_cnt = lu_cnt_q;
   assign Flush_cnt   = fl_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus randomized traffic
// checked against a cycle-count model of the hazard rules.
module tb_hazard_ctrl;

   localparam int MUL_LAT = 4;
   localparam int DIV_LAT = 16;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [4:0]  id_rs = '0, id_rt = '0, ex_rd = '0;
   logic        id_usesrt = 0, id_jump = 0, ex_memread = 0;
   logic        ex_br = 0, ex_start = 0, ex_isdiv = 0;
   logic        pc_stall, ifid_stall, ifid_flush, id_stall, id_flush;
   logic        exmem_flush, mdu_busy, mdu_done;
   logic [15:0] lu_cnt, fl_cnt;
   logic [7:0]  outs;

   int n_checks = 0;
   int n_fail = 0;

   // model state: remaining stall cycles after this one, done pulse pending
   int busy_left = 0;
   bit done_now = 0;
   int m_lu = 0;
   int m_fl = 0;

   hazard_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
      .clk(clk), .reset(reset),
      .ID_RegRs(id_rs), .ID_RegRt(id_rt), .ID_UsesRt(id_usesrt),
      .ID_Jump(id_jump), .EX_MemRead(ex_memread), .EX_RegWrAddr(ex_rd),
      .EX_BranchTaken(ex_br), .EX_MDUStart(ex_start), .EX_MDUIsDiv(ex_isdiv),
      .PC_stall(pc_stall), .IF_ID_stall(ifid_stall), .IF_ID_flush(ifid_flush),
      .ID_stall(id_stall), .ID_flush(id_flush), .EX_MEM_flush(exmem_flush),
      .MDU_busy(mdu_busy), .MDU_done(mdu_done),
      .LoadUse_cnt(lu_cnt), .Flush_cnt(fl_cnt)
   );

   always #5 clk = ~clk;

   assign outs = {pc_stall, ifid_stall, ifid_flush, id_stall,
                  id_flush, exmem_flush, mdu_busy, mdu_done};

   initial begin
      #5ms;
      $display("FAIL watchdog: time limit expired");
      $fatal(1, "watchdog");
   end

   // which rule applies this cycle: 1 mdu, 2 branch, 3 load-use, 4 jump, 0 none
   function automatic int prio();
      bit lu, ms;
      lu = ex_memread && ex_rd != 0 &&
           (ex_rd == id_rs || (id_usesrt && ex_rd == id_rt));
      ms = (busy_left > 0) || (!done_now && ex_start);
      if (ms) return 1;
      if (ex_br) return 2;
      if (lu) return 3;
      if (id_jump) return 4;
      return 0;
   endfunction

   function automatic logic [7:0] exp_outs();
      logic [7:0] v;
      case (prio())
         1: v = 8'b1101_0110;
         2: v = 8'b0010_1000;
         3: v = 8'b1100_1000;
         4: v = 8'b0010_0000;
         default: v = 8'b0;
      endcase
      v[0] = done_now;
      return v;
   endfunction

   task automatic model_reset();
      busy_left = 0;
      done_now  = 0;
      m_lu      = 0;
      m_fl      = 0;
   endtask

   // advance the model across one clock edge
   task automatic model_tick();
      int p;
      p = prio();
      if (p == 3 && m_lu < 65535) m_lu++;
      if ((p == 2 || p == 4) && m_fl < 65535) m_fl++;
      if (busy_left > 0) begin
         busy_left--;
         if (busy_left == 0) done_now = 1;
      end else if (done_now) begin
         done_now = 0;
      end else if (ex_start) begin
         busy_left = (ex_isdiv ? DIV_LAT : MUL_LAT) - 1;
      end
   endtask

   task automatic clear_inputs();
      id_rs = 0; id_rt = 0; ex_rd = 0;
      id_usesrt = 0; id_jump = 0; ex_memread = 0;
      ex_br = 0; ex_start = 0; ex_isdiv = 0;
   endtask

   task automatic edge_tick();
      @(posedge clk);
      model_tick();
      #1;
   endtask

   task automatic test_reset();
      reset = 0;
      for (int i = 0; i < 4; i++) begin
         {id_rs, id_rt, ex_rd} = 15'($urandom);
         {id_usesrt, id_jump, ex_memread, ex_br, ex_start, ex_isdiv} = 6'($urandom);
         @(negedge clk);
         n_checks++;
         if (outs !== 8'b0 || lu_cnt !== 16'd0 || fl_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_%0d: outs=%b lu=%0d fl=%0d want all 0",
                     i, outs, lu_cnt, fl_cnt);
         end
      end
      clear_inputs();
      model_reset();
      @(negedge clk);
      reset = 1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_load_use();
      int lu0;
      lu0 = m_lu;
      clear_inputs();
      ex_memread = 1; ex_rd = 5; id_rs = 5;
      @(negedge clk);
      n_checks++;
      if (outs !== 8'b1100_1000) begin
         n_fail++;
         $display("FAIL lu_rs: outs=%b want %b", outs, 8'b1100_1000);
      end
      edge_tick();
      n_checks++;
      if (lu_cnt !== 16'(lu0 + 1)) begin
         n_fail++;
         $display("FAIL lu_cnt: got %0d want %0d", lu_cnt, lu0 + 1);
      end
      ex_rd = 0; id_rs = 0;
      @(negedge clk);
      n_checks++;
      if (outs !== 8'b0) begin
         n_fail++;
         $display("FAIL lu_zero: outs=%b want 0", outs);
      end
      edge_tick();
      ex_rd = 7; id_rs = 3; id_rt = 7; id_usesrt = 0;
      @(negedge clk);
      n_checks++;
      if (outs !== 8'b0) begin
         n_fail++;
         $display("FAIL lu_rt_unused: outs=%b want 0", outs);
      end
      edge_tick();
      id_usesrt = 1;
      @(negedge clk);
      n_checks++;
      if (outs !== exp_outs() || outs !== 8'b1100_1000) begin
         n_fail++;
         $display("FAIL lu_rt_used: outs=%b want %b", outs, 8'b1100_1000);
      end
      edge_tick();
      clear_inputs();
      n_checks++;
      if (lu_cnt !== 16'(m_lu) || m_lu != lu0 + 2) begin
         n_fail++;
         $display("FAIL lu_cnt2: got %0d want %0d", lu_cnt, lu0 + 2);
      end
   endtask

   task automatic test_mdu(input bit div);
      int nb, nd, lat;
      nb = 0; nd = 0;
      lat = div ? DIV_LAT : MUL_LAT;
      clear_inputs();
      ex_start = 1; ex_isdiv = div;
      for (int c = 0; c <= lat; c++) begin
         @(negedge clk);
         if (mdu_busy) nb++;
         if (mdu_done) nd++;
         n_checks++;
         if (outs !== exp_outs()) begin
            n_fail++;
            $display("FAIL mdu_div%0d_cyc%0d: outs=%b want %b",
                     div, c, outs, exp_outs());
         end
         edge_tick();
      end
      n_checks++;
      if (nb != lat || nd != 1) begin
         n_fail++;
         $display("FAIL mdu_len_div%0d: busy=%0d done=%0d want %0d 1",
                  div, nb, nd, lat);
      end
      ex_start = 0;
      @(negedge clk);
      n_checks++;
      if (outs !== 8'b0) begin
         n_fail++;
         $display("FAIL mdu_idle_div%0d: outs=%b want 0", div, outs);
      end
      edge_tick();
   endtask

   task automatic test_priority();
      int lu0, fl0;
      lu0 = m_lu; fl0 = m_fl;
      clear_inputs();
      ex_br = 1; ex_memread = 1; ex_rd = 9; id_rs = 9; id_jump = 1;
      @(negedge clk);
      n_checks++;
      if (outs !== 8'b0010_1000) begin
         n_fail++;
         $display("FAIL prio_branch: outs=%b want %b", outs, 8'b0010_1000);
      end
      edge_tick();
      n_checks++;
      if (fl_cnt !== 16'(fl0 + 1) || lu_cnt !== 16'(lu0)) begin
         n_fail++;
         $display("FAIL prio_branch_cnt: fl=%0d lu=%0d want %0d %0d",
                  fl_cnt, lu_cnt, fl0 + 1, lu0);
      end
      ex_br = 0;
      @(negedge clk);
      n_checks++;
      if (outs !== 8'b1100_1000) begin
         n_fail++;
         $display("FAIL prio_lu_jump: outs=%b want %b", outs, 8'b1100_1000);
      end
      edge_tick();
      n_checks++;
      if (fl_cnt !== 16'(fl0 + 1) || lu_cnt !== 16'(lu0 + 1)) begin
         n_fail++;
         $display("FAIL prio_lu_cnt: fl=%0d lu=%0d want %0d %0d",
                  fl_cnt, lu_cnt, fl0 + 1, lu0 + 1);
      end
      clear_inputs();
   endtask

   task automatic test_random(input int n);
      for (int c = 0; c < n; c++) begin
         ex_rd = 5'($urandom_range(0, 3));
         id_rs = 5'($urandom_range(0, 3));
         id_rt = 5'($urandom_range(0, 3));
         id_usesrt = 1'($urandom);
         id_jump = ($urandom_range(0, 3) == 0);
         ex_memread = 1'($urandom);
         ex_start = ($urandom_range(0, 15) == 0);
         ex_isdiv = 1'($urandom);
         ex_br = (busy_left == 0 && !done_now) ? ($urandom_range(0, 4) == 0) : 1'b0;
         @(negedge clk);
         n_checks++;
         if (outs !== exp_outs() || lu_cnt !== 16'(m_lu) || fl_cnt !== 16'(m_fl)) begin
            n_fail++;
            $display("FAIL rand_cyc%0d: outs=%b lu=%0d fl=%0d want %b %0d %0d",
                     c, outs, lu_cnt, fl_cnt, exp_outs(), m_lu, m_fl);
         end
         edge_tick();
      end
      // let any MDU operation drain
      clear_inputs();
      for (int c = 0; c < DIV_LAT + 2; c++) edge_tick();
   endtask

   task automatic test_reset_mid();
      int nd;
      nd = 0;
      clear_inputs();
      ex_start = 1; ex_isdiv = 1;
      for (int c = 0; c < 4; c++) edge_tick();
      reset = 0;
      #1;
      n_checks++;
      if (outs !== 8'b0 || lu_cnt !== 16'd0 || fl_cnt !== 16'd0) begin
         n_fail++;
         $display("FAIL reset_mid: outs=%b lu=%0d fl=%0d want all 0",
                  outs, lu_cnt, fl_cnt);
      end
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      ex_start = 0;
      reset = 1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (mdu_done) nd++;
         n_checks++;
         if (outs !== exp_outs()) begin
            n_fail++;
            $display("FAIL reset_rel_cyc%0d: outs=%b want %b", c, outs, exp_outs());
         end
         edge_tick();
      end
      n_checks++;
      if (nd != 0) begin
         n_fail++;
         $display("FAIL reset_no_done: done pulses=%0d want 0", nd);
      end
   endtask

   task automatic test_saturation();
      clear_inputs();
      id_jump = 1;
      for (int c = 0; c < 65540; c++) edge_tick();
      n_checks++;
      if (fl_cnt !== 16'hFFFF || m_fl != 65535) begin
         n_fail++;
         $display("FAIL fl_sat: got %h want ffff", fl_cnt);
      end
      @(negedge clk);
      n_checks++;
      if (outs !== 8'b0010_0000) begin
         n_fail++;
         $display("FAIL fl_sat_outs: outs=%b want %b", outs, 8'b0010_0000);
      end
      edge_tick();
      n_checks++;
      if (fl_cnt !== 16'hFFFF || lu_cnt !== 16'(m_lu)) begin
         n_fail++;
         $display("FAIL fl_sat_hold: fl=%h lu=%0d want ffff %0d",
                  fl_cnt, lu_cnt, m_lu);
      end
      clear_inputs();
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_mdu(1'b1);
      test_mdu(1'b0);
      test_priority();
      test_random(1500);
      test_reset_mid();
      test_random(500);
      test_saturation();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
